// File: rtl/corelet_if.sv
// corelet_if -- command, status and memory-strobe bundle of the corelet
// controller.
//
// Signals (direction as seen from the controller, i.e. the slave modport):
//   in : start, acc_mode, w_base, a_base, p_base, ofifo_valid
//   out: xmem_rd, xmem_addr, l0_wr, l0_rd, inst_w, ofifo_rd, pmem_rd,
//        pmem_wr, pmem_raddr, pmem_waddr, sfp_acc_en, busy, done, state
//
// ofifo_valid / ofifo_rd form the only handshake: ofifo_valid means the
// OFIFO holds a complete row; a row is popped in every cycle where
// ofifo_rd=1, and ofifo_rd is only ever high while ofifo_valid is high.
//
// state is a debug view of the FSM: 0 IDLE, 1 WLOAD, 2 WKERN, 3 WSETTLE,
// 4 ALOAD, 5 AEXEC, 6 DRAIN, 7 DONE.
interface corelet_if #(
  parameter int addr_bw = 11
);
  logic               start;
  logic               acc_mode;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] a_base;
  logic [addr_bw-1:0] p_base;
  logic               ofifo_valid;

  logic               xmem_rd;
  logic [addr_bw-1:0] xmem_addr;
  logic               l0_wr;
  logic               l0_rd;
  logic [1:0]         inst_w;
  logic               ofifo_rd;
  logic               pmem_rd;
  logic               pmem_wr;
  logic [addr_bw-1:0] pmem_raddr;
  logic [addr_bw-1:0] pmem_waddr;
  logic               sfp_acc_en;
  logic               busy;
  logic               done;
  logic [2:0]         state;

  // Side that issues passes and observes the strobes.
  modport master (
    output start, acc_mode, w_base, a_base, p_base, ofifo_valid,
    input  xmem_rd, xmem_addr, l0_wr, l0_rd, inst_w, ofifo_rd, pmem_rd,
           pmem_wr, pmem_raddr, pmem_waddr, sfp_acc_en, busy, done, state
  );

  // The controller itself.
  modport slave (
    input  start, acc_mode, w_base, a_base, p_base, ofifo_valid,
    output xmem_rd, xmem_addr, l0_wr, l0_rd, inst_w, ofifo_rd, pmem_rd,
           pmem_wr, pmem_raddr, pmem_waddr, sfp_acc_en, busy, done, state
  );
endinterface

// File: rtl/corelet_ctrl.sv
// corelet_ctrl -- sequencer for one corelet pass:
//   load col weight rows XMEM->L0, push them into the PE array (kernel load),
//   let the weights settle for row cycles, load len_nij activation vectors
//   XMEM->L0, execute them, then drain len_nij output rows from the OFIFO
//   through the SFP into PMEM (read psum, optionally accumulate, write back).
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high; returns to IDLE with all outputs 0
//   bus    corelet_if.slave (command inputs, memory strobes, status)
//
// Parameters: row (PE rows), col (PE columns / weight rows), len_nij
// (activation vectors per pass, 1..63), addr_bw (address width).
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_nij = 36,
  parameter int addr_bw = 11
) (
  input  logic     clk,
  input  logic     reset,
  corelet_if.slave bus
);

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_wload   = 3'd1,
    st_wkern   = 3'd2,
    st_wsettle = 3'd3,
    st_aload   = 3'd4,
    st_aexec   = 3'd5,
    st_drain   = 3'd6,
    st_done    = 3'd7
  } state_t;

  localparam int max_rc = (col > row) ? col : row;
  localparam int max_n  = (max_rc > len_nij) ? max_rc : len_nij;
  // Phase counter must reach col / len_nij (the last load cycle) plus one.
  localparam int cw     = $clog2(max_n + 2);
  localparam int kw     = $clog2(len_nij + 1);

  typedef logic [addr_bw-1:0] addr_t;
  typedef logic [cw-1:0]      cnt_t;
  typedef logic [kw-1:0]      k_t;

  state_t state_q;
  cnt_t   cnt;
  cnt_t   cnt_inc;
  k_t     k;

  // Latched pass configuration.
  logic  acc_q;
  addr_t w_base_q;
  addr_t a_base_q;
  addr_t p_base_q;

  // Drain pipeline: pop in t, SFP in t+1, PMEM write in t+2.
  logic  drain_en;
  logic  pop;
  logic  pop_d1;
  addr_t waddr_d1;

  // Output registers.
  logic       xmem_rd_q;
  addr_t      xmem_addr_q;
  logic       l0_wr_q;
  logic       l0_rd_q;
  logic [1:0] inst_w_q;
  addr_t      pmem_raddr_q;
  addr_t      pmem_waddr_q;
  logic       pmem_wr_q;
  logic       sfp_acc_en_q;
  logic       busy_q;
  logic       done_q;

  assign cnt_inc = cnt + cnt_t'(1);

  // The pop must follow ofifo_valid in the same cycle (a row can vanish or
  // arrive at any time), so it is a registered enable gated by the live
  // valid. drain_en already encodes "in DRAIN and k < len_nij".
  assign pop = drain_en & bus.ofifo_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= st_idle;
      cnt          <= '0;
      k            <= '0;
      acc_q        <= 1'b0;
      w_base_q     <= '0;
      a_base_q     <= '0;
      p_base_q     <= '0;
      drain_en     <= 1'b0;
      pop_d1       <= 1'b0;
      waddr_d1     <= '0;
      xmem_rd_q    <= 1'b0;
      xmem_addr_q  <= '0;
      l0_wr_q      <= 1'b0;
      l0_rd_q      <= 1'b0;
      inst_w_q     <= 2'b00;
      pmem_raddr_q <= '0;
      pmem_waddr_q <= '0;
      pmem_wr_q    <= 1'b0;
      sfp_acc_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Every branch below sets the outputs for the cycle it moves into,
      // so outputs line up with (state_q, cnt) of that cycle.
      xmem_rd_q    <= 1'b0;
      l0_wr_q      <= 1'b0;
      l0_rd_q      <= 1'b0;
      inst_w_q     <= 2'b00;
      done_q       <= 1'b0;
      sfp_acc_en_q <= pop & acc_q;
      pmem_wr_q    <= pop_d1;
      pop_d1       <= pop;
      if (pop)    waddr_d1     <= pmem_raddr_q;
      if (pop_d1) pmem_waddr_q <= waddr_d1;

      case (state_q)
        st_idle: begin
          if (bus.start) begin
            state_q     <= st_wload;
            cnt         <= '0;
            acc_q       <= bus.acc_mode;
            w_base_q    <= bus.w_base;
            a_base_q    <= bus.a_base;
            p_base_q    <= bus.p_base;
            busy_q      <= 1'b1;
            xmem_rd_q   <= 1'b1;
            xmem_addr_q <= bus.w_base;
          end
        end

        // Reads in cycles 0..col-1, L0 writes trail them by one cycle.
        st_wload: begin
          if (cnt == cnt_t'(col)) begin
            state_q  <= st_wkern;
            cnt      <= '0;
            l0_rd_q  <= 1'b1;
            inst_w_q <= 2'b01;
          end else begin
            cnt     <= cnt_inc;
            l0_wr_q <= 1'b1;
            if (cnt_inc < cnt_t'(col)) begin
              xmem_rd_q   <= 1'b1;
              xmem_addr_q <= w_base_q + addr_t'(cnt_inc);
            end
          end
        end

        st_wkern: begin
          if (cnt == cnt_t'(col - 1)) begin
            state_q <= st_wsettle;
            cnt     <= '0;
          end else begin
            cnt      <= cnt_inc;
            l0_rd_q  <= 1'b1;
            inst_w_q <= 2'b01;
          end
        end

        // Weights ripple down row PE rows before activations may follow.
        st_wsettle: begin
          if (cnt == cnt_t'(row - 1)) begin
            state_q     <= st_aload;
            cnt         <= '0;
            xmem_rd_q   <= 1'b1;
            xmem_addr_q <= a_base_q;
          end else begin
            cnt <= cnt_inc;
          end
        end

        st_aload: begin
          if (cnt == cnt_t'(len_nij)) begin
            state_q  <= st_aexec;
            cnt      <= '0;
            l0_rd_q  <= 1'b1;
            inst_w_q <= 2'b10;
          end else begin
            cnt     <= cnt_inc;
            l0_wr_q <= 1'b1;
            if (cnt_inc < cnt_t'(len_nij)) begin
              xmem_rd_q   <= 1'b1;
              xmem_addr_q <= a_base_q + addr_t'(cnt_inc);
            end
          end
        end

        st_aexec: begin
          if (cnt == cnt_t'(len_nij - 1)) begin
            state_q      <= st_drain;
            cnt          <= '0;
            k            <= '0;
            drain_en     <= 1'b1;
            pmem_raddr_q <= p_base_q;
          end else begin
            cnt      <= cnt_inc;
            l0_rd_q  <= 1'b1;
            inst_w_q <= 2'b10;
          end
        end

        // pmem_raddr always shows p_base+k; it stops advancing after the
        // last pop so it holds the last address actually read.
        st_drain: begin
          if (pop) begin
            k <= k + k_t'(1);
            if (k == k_t'(len_nij - 1)) begin
              drain_en <= 1'b0;
            end else begin
              pmem_raddr_q <= pmem_raddr_q + addr_t'(1);
            end
          end
          // k reached len_nij and the last pop is one stage in: its write
          // lands in the next cycle, which is the DONE cycle.
          if (pop_d1 && (k == k_t'(len_nij))) begin
            state_q <= st_done;
            done_q  <= 1'b1;
          end
        end

        st_done: begin
          state_q <= st_idle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= st_idle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.xmem_rd    = xmem_rd_q;
  assign bus.xmem_addr  = xmem_addr_q;
  assign bus.l0_wr      = l0_wr_q;
  assign bus.l0_rd      = l0_rd_q;
  assign bus.inst_w     = inst_w_q;
  assign bus.ofifo_rd   = pop;
  assign bus.pmem_rd    = pop;
  assign bus.pmem_wr    = pmem_wr_q;
  assign bus.pmem_raddr = pmem_raddr_q;
  assign bus.pmem_waddr = pmem_waddr_q;
  assign bus.sfp_acc_en = sfp_acc_en_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.state      = state_q;

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 Parameter row, default 8: L0 lanes / PE rows.
REQ-002 Parameter col, default 8: PE columns; weight rows per kernel load.
REQ-003 Parameter len_nij, default 36: activation vectors per pass; legal range 1..63.
REQ-004 Parameter addr_bw, default 11: XMEM/PMEM address width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 start  in  1  one-cycle request to run one pass; sampled only in IDLE.
REQ-008 acc_mode  in  1  1 = accumulate into existing PMEM psums, 0 = overwrite; latched at start.
REQ-009 w_base, a_base, p_base  in  addr_bw each  weight, activation and psum base addresses; latched at start.
REQ-010 ofifo_valid  in  1  OFIFO holds at least one complete output row.
REQ-011 xmem_rd  out  1  XMEM read enable.
REQ-012 xmem_addr  out  addr_bw  XMEM read address.
REQ-013 l0_wr, l0_rd  out  1 each  L0 write and read strobes.
REQ-014 inst_w  out  2  MAC array instruction: 01 = kernel load, 10 = execute, 00 = idle.
REQ-015 ofifo_rd  out  1  OFIFO pop.
REQ-016 pmem_rd, pmem_wr  out  1 each  PMEM read and write enables.
REQ-017 pmem_raddr, pmem_waddr  out  addr_bw each  PMEM read and write addresses.
REQ-018 sfp_acc_en  out  1  SFP accumulate enable.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse at pass completion.

Function
REQ-021 FSM states SHALL be IDLE, WLOAD, WKERN, WSETTLE, ALOAD, AEXEC, DRAIN, DONE, and each state SHALL exit only via the transition listed below.
REQ-022 IDLE->WLOAD on start; start SHALL have no effect in any other state.
REQ-023 Memory timing: XMEM read issued in cycle t delivers data in t+1; l0_wr SHALL be asserted in t+1 for each read issued in t.
REQ-024 WLOAD: col+1 cycles.
- xmem_rd=1 in cycles 0..col-1, with xmem_addr=w_base+i.
- l0_wr=1 in cycles 1..col.
- Then ->WKERN.
REQ-025 WKERN: col cycles with l0_rd=1 and inst_w=01, then ->WSETTLE.
REQ-026 WSETTLE: row cycles with inst_w=00 and no strobes, then ->ALOAD.
REQ-027 ALOAD: identical to WLOAD but len_nij reads at a_base+i, len_nij+1 cycles, then ->AEXEC.
REQ-028 AEXEC: len_nij cycles with l0_rd=1 and inst_w=10, then ->DRAIN.
REQ-029 DRAIN keeps a pop counter k (0..len_nij-1); in any cycle t with ofifo_valid=1 and k<len_nij:
- ofifo_rd=1, pmem_rd=1, pmem_raddr=p_base+k, k increments.
- In t+1: sfp_acc_en=acc_mode (latched).
- In t+2: pmem_wr=1, pmem_waddr=p_base+k(t).
REQ-030 ofifo_rd SHALL never assert while ofifo_valid=0; pops may be back-to-back and gaps SHALL be tolerated indefinitely.
REQ-031 DRAIN->DONE two cycles after the pop with k=len_nij-1, i.e. after the last write; DONE lasts 1 cycle with done=1, then ->IDLE.
REQ-032 Address arithmetic SHALL be modulo 2^addr_bw (base+i wraps silently).
REQ-033 All outputs SHALL be registered; strobes not listed for a state SHALL be 0, and addresses SHALL hold their last value.

Reset
REQ-034 Reset SHALL force IDLE, clear counters, latched config and pipeline delay stages, and drive every output to 0, including mid-pass.
REQ-035 A start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-036 start, w_base=0, a_base=64 -> xmem_addr 0..7 with l0_wr one cycle later; inst_w=01 for 8 cycles; 8 idle cycles; xmem_addr 64..99; inst_w=10 for 36 cycles.
REQ-037 ofifo_valid held 1, p_base=100, acc_mode=1 -> pmem_raddr 100..135 on consecutive cycles; pmem_waddr 100..135 exactly 2 cycles later; sfp_acc_en=1 on each t+1; done exactly once, 2 cycles after the last pop.
REQ-038 ofifo_valid toggling 1,0,0,1 pattern -> ofifo_rd only when valid=1; still exactly 36 pops and 36 writes; acc_mode=0 gives sfp_acc_en=0 throughout.
REQ-039 Second start pulse during AEXEC -> ignored; busy stays 1; exactly one done pulse.
REQ-040 reset asserted mid-DRAIN after 10 pops -> next cycle all outputs 0 and state IDLE; a new start runs a full pass from WLOAD.
REQ-041 p_base=2040, addr_bw=11 -> pmem addresses 2040..2047 then wrap to 0..27.
